// File: rtl/yutorina_spm_arbiter_pkg.sv
// Shared SPM definitions: arbiter state encoding, requester IDs, read/write encoding.
// Used by the arbiter top and its tie-break picker.
package yutorina_spm_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_M0 = 2'd1,
        GRANT_M1 = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_id_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/yutorina_spm_arbiter_pick.sv
// Combinational tie-break between the two SPM requesters.
// YUTORINA_SPM_ARB_ROUND_ROBIN_EN: ties go to the non-last owner; otherwise m0 always wins.
module yutorina_spm_arbiter_pick
    import yutorina_spm_arbiter_pkg::*;
(
    input  logic    i_m0_req,
    input  logic    i_m1_req,
`ifdef YUTORINA_SPM_ARB_ROUND_ROBIN_EN
    input  req_id_e i_last_owner,
`endif
    output logic    o_valid,
    output req_id_e o_winner
);

    always_comb begin
        o_valid  = i_m0_req | i_m1_req;
        o_winner = REQ_M0;
        if (i_m0_req && i_m1_req) begin
`ifdef YUTORINA_SPM_ARB_ROUND_ROBIN_EN
            o_winner = (i_last_owner == REQ_M0) ? REQ_M1 : REQ_M0;
`else
            o_winner = REQ_M0;
`endif
        end else if (i_m1_req) begin
            o_winner = REQ_M1;
        end
    end

endmodule

// File: rtl/yutorina_spm_arbiter.sv
// Two-master arbiter for the SPM data port (m0 = CPU memory stage, m1 = loader) with lock support.
// YUTORINA_SPM_ARB_ROUND_ROBIN_EN enables round-robin tie-break and the last-owner register.
module yutorina_spm_arbiter
    import yutorina_spm_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_m0_req,
    input  logic              i_m1_req,
    input  logic              i_m0_lock,
    input  logic              i_m1_lock,
    input  logic [ADDR_W-1:0] i_m0_address,
    input  logic [ADDR_W-1:0] i_m1_address,
    input  logic              i_m0_read_write,
    input  logic              i_m1_read_write,
    input  logic [DATA_W-1:0] i_m0_write_data,
    input  logic [DATA_W-1:0] i_m1_write_data,
    output logic              o_m0_grant,
    output logic              o_m1_grant,
    output logic              o_m0_ready,
    output logic              o_m1_ready,
    output logic [DATA_W-1:0] o_read_data,
    output logic [ADDR_W-1:0] o_spm_address,
    output logic              o_spm_read_write,
    output logic [DATA_W-1:0] o_spm_write_data,
    output logic              o_spm_address_strobe_,
    input  logic [DATA_W-1:0] i_spm_read_data
);

    localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_e        r_state;
    arb_state_e        w_next_state;
    arb_state_e        w_pick_state;
    logic [CNT_W-1:0]  r_lock_cnt;
    logic [CNT_W-1:0]  w_next_cnt;
    logic              r_m0_ready;
    logic              r_m1_ready;
    logic [DATA_W-1:0] r_read_data;
    logic              w_m0_acc;
    logic              w_m1_acc;
    logic              w_pick_valid;
    req_id_e           w_pick_winner;

`ifdef YUTORINA_SPM_ARB_ROUND_ROBIN_EN
    req_id_e           r_last_owner;
`endif

    assign o_m0_grant  = (r_state == GRANT_M0);
    assign o_m1_grant  = (r_state == GRANT_M1);
    assign o_m0_ready  = r_m0_ready;
    assign o_m1_ready  = r_m1_ready;
    assign o_read_data = r_read_data;

    assign w_m0_acc = o_m0_grant & i_m0_req;
    assign w_m1_acc = o_m1_grant & i_m1_req;

    yutorina_spm_arbiter_pick u_pick (
        .i_m0_req     (i_m0_req),
        .i_m1_req     (i_m1_req),
`ifdef YUTORINA_SPM_ARB_ROUND_ROBIN_EN
        .i_last_owner (r_last_owner),
`endif
        .o_valid      (w_pick_valid),
        .o_winner     (w_pick_winner)
    );

    assign w_pick_state = !w_pick_valid            ? IDLE     :
                          (w_pick_winner == REQ_M0) ? GRANT_M0 : GRANT_M1;

    // Counter defaults to clear; only a held lock below the limit advances it,
    // and a saturated lock with the other side idle keeps it.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = '0;
        unique case (r_state)
            IDLE: w_next_state = w_pick_state;
            GRANT_M0: begin
                if (!i_m0_lock) begin
                    w_next_state = w_pick_state;
                end else if (r_lock_cnt < CNT_LAST) begin
                    w_next_cnt = r_lock_cnt + CNT_W'(1);
                end else if (i_m1_req) begin
                    w_next_state = GRANT_M1;
                end else begin
                    w_next_cnt = r_lock_cnt;
                end
            end
            GRANT_M1: begin
                if (!i_m1_lock) begin
                    w_next_state = w_pick_state;
                end else if (r_lock_cnt < CNT_LAST) begin
                    w_next_cnt = r_lock_cnt + CNT_W'(1);
                end else if (i_m0_req) begin
                    w_next_state = GRANT_M0;
                end else begin
                    w_next_cnt = r_lock_cnt;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_spm_address_strobe_ = 1'b1;
        o_spm_address         = '0;
        o_spm_read_write      = RW_READ;
        o_spm_write_data      = '0;
        if (w_m0_acc) begin
            o_spm_address_strobe_ = 1'b0;
            o_spm_address         = i_m0_address;
            o_spm_read_write      = i_m0_read_write;
            o_spm_write_data      = i_m0_write_data;
        end else if (w_m1_acc) begin
            o_spm_address_strobe_ = 1'b0;
            o_spm_address         = i_m1_address;
            o_spm_read_write      = i_m1_read_write;
            o_spm_write_data      = i_m1_write_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_lock_cnt  <= '0;
            r_m0_ready  <= 1'b0;
            r_m1_ready  <= 1'b0;
            r_read_data <= '0;
        end else begin
            r_state    <= w_next_state;
            r_lock_cnt <= w_next_cnt;
            r_m0_ready <= w_m0_acc;
            r_m1_ready <= w_m1_acc;
            if ((w_m0_acc && i_m0_read_write == RW_READ) ||
                (w_m1_acc && i_m1_read_write == RW_READ)) begin
                r_read_data <= i_spm_read_data;
            end
        end
    end

`ifdef YUTORINA_SPM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_last_owner <= REQ_M1;
        end else if (w_next_state == GRANT_M0) begin
            r_last_owner <= REQ_M0;
        end else if (w_next_state == GRANT_M1) begin
            r_last_owner <= REQ_M1;
        end
    end
`endif

endmodule

// File: tb/tb_yutorina_spm_arbiter.sv
// Self-checking bench for yutorina_spm_arbiter: directed sequences, a vector table and a
// randomized run against a reference model. Honors YUTORINA_SPM_ARB_ROUND_ROBIN_EN.
module tb_yutorina_spm_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int LM = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req   [2];
    logic          lock  [2];
    logic          rw    [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wd    [2];
    logic          g0, g1, rdy0, rdy1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] spm_addr;
    logic          spm_rw;
    logic [DW-1:0] spm_wd;
    logic          strobe_n;
    logic [DW-1:0] spm_rd;

    logic [DW-1:0] mem     [0:4095];
    logic [DW-1:0] ref_mem [0:4095];
    logic          mem_init;

    int n_vec = 0;
    int n_bad = 0;

    yutorina_spm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
        .i_clock               (clk),
        .i_reset               (rst),
        .i_m0_req              (req[0]),
        .i_m1_req              (req[1]),
        .i_m0_lock             (lock[0]),
        .i_m1_lock             (lock[1]),
        .i_m0_address          (addr[0]),
        .i_m1_address          (addr[1]),
        .i_m0_read_write       (rw[0]),
        .i_m1_read_write       (rw[1]),
        .i_m0_write_data       (wd[0]),
        .i_m1_write_data       (wd[1]),
        .o_m0_grant            (g0),
        .o_m1_grant            (g1),
        .o_m0_ready            (rdy0),
        .o_m1_ready            (rdy1),
        .o_read_data           (rdata),
        .o_spm_address         (spm_addr),
        .o_spm_read_write      (spm_rw),
        .o_spm_write_data      (spm_wd),
        .o_spm_address_strobe_ (strobe_n),
        .i_spm_read_data       (spm_rd)
    );

    initial forever #5 clk = ~clk;

    // SPM model: combinational read, write on the strobed edge.
    assign spm_rd = mem[spm_addr];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++)
                mem[i] <= (i == 16) ? 32'hDEADBEEF : (i * 32'h9E3779B9) ^ 32'h5A5A0000;
        end else if (!strobe_n && !spm_rw) begin
            mem[spm_addr] <= spm_wd;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; lock[k] = 1'b0; rw[k] = 1'b1; addr[k] = '0; wd[k] = '0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic int pick(input bit a, input bit b, input int last);
        if (a && b) begin
`ifdef YUTORINA_SPM_ARB_ROUND_ROBIN_EN
            return (last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (a) return 0;
        if (b) return 1;
        return -1;
    endfunction

    typedef struct {
        logic       r0;
        logic       r1;
        logic [3:0] exp;   // {g0, g1, rdy0, rdy1} after the edge
    } vec_t;

    vec_t tbl [9];

    int            owner, run, last, o, held, lows, badidle;
    bit            acc, erdy0, erdy1, nr0, nr1;
    bit            pend [2];
    logic [DW-1:0] erd;
    logic [AW-1:0] e_addr;
    logic          e_rw, e_stb;
    logic [DW-1:0] e_wd;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 4'b1000};
        tbl[1] = '{1'b1, 1'b0, 4'b1010};
        tbl[2] = '{1'b0, 1'b1, 4'b0100};
        tbl[3] = '{1'b0, 1'b1, 4'b0101};
        tbl[4] = '{1'b0, 1'b0, 4'b0000};
        tbl[5] = '{1'b1, 1'b1, 4'b1000};
`ifdef YUTORINA_SPM_ARB_ROUND_ROBIN_EN
        tbl[6] = '{1'b1, 1'b1, 4'b0110};
        tbl[7] = '{1'b1, 1'b1, 4'b1001};
`else
        tbl[6] = '{1'b1, 1'b1, 4'b1010};
        tbl[7] = '{1'b1, 1'b1, 4'b1010};
`endif
        tbl[8] = '{1'b0, 1'b0, 4'b0000};

        mem_init = 1'b1;
        do_reset();
        mem_init = 1'b0;

        // Reset state
        check("reset_grant_ready", {g0, g1, rdy0, rdy1}, 4'b0000);
        check("reset_read_data", rdata, 32'h0);
        #4;
        check("reset_idle_port", {strobe_n, spm_addr, spm_rw, spm_wd}, {1'b1, 12'h0, 1'b1, 32'h0});
        tick();

        // m0 read of 0x010: grant at cycle 1, ready and data at cycle 2
        do_reset();
        req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 12'h010;
        tick();
        check("rd_grant_c1", {g0, g1}, 2'b10);
        #4;
        check("rd_port_c1", {strobe_n, spm_addr, spm_rw}, {1'b0, 12'h010, 1'b1});
        tick();
        req[0] = 1'b0;
        check("rd_ready_c2", {rdy0, rdy1}, 2'b10);
        check("rd_data_c2", rdata, 32'hDEADBEEF);
        tick();
        check("rd_ready_pulse", {rdy0, rdy1}, 2'b00);

        // m0 write of 0x12345678 to 0x3FF; read_data must keep the earlier value
        req[0] = 1'b1; rw[0] = 1'b0; addr[0] = 12'h3FF; wd[0] = 32'h12345678;
        tick();
        check("wr_grant", g0, 1'b1);
        #4;
        check("wr_port", {strobe_n, spm_rw, spm_addr, spm_wd}, {1'b0, 1'b0, 12'h3FF, 32'h12345678});
        tick();
        req[0] = 1'b0;
        check("wr_ready", {rdy0, rdy1}, 2'b10);
        check("wr_read_data_hold", rdata, 32'hDEADBEEF);
        check("wr_mem", mem[12'h3FF], 32'h12345678);

        // Table: sole requests, idle return and simultaneous requests
        do_reset();
        for (int i = 0; i < 9; i++) begin
            req[0] = tbl[i].r0; req[1] = tbl[i].r1;
            addr[0] = AW'(i); addr[1] = AW'(i + 100);
            tick();
            check($sformatf("table_row%0d", i), {g0, g1, rdy0, rdy1}, tbl[i].exp);
        end

        // m1 lock hold limit with m0 waiting
        do_reset();
        req[1] = 1'b1; lock[1] = 1'b1; rw[1] = 1'b0; addr[1] = 12'h200; wd[1] = 32'hA0;
        tick();
        req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 12'h005;
        held = 0;
        while (g1 && held < 40) begin
            held++;
            addr[1] = addr[1] + 1'b1; wd[1] = wd[1] + 1;
            tick();
        end
        check("lock_hold_cycles", held, LM);
        check("lock_forced_handover", {g0, g1}, 2'b10);

        // m1 lock with no request: grant held, counter saturates, idle port
        do_reset();
        req[1] = 1'b1; lock[1] = 1'b1; rw[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        lows = 0; badidle = 0;
        for (int c = 0; c < 30; c++) begin
            #4;
            if (!strobe_n) lows++;
            if ({spm_addr, spm_rw, spm_wd} !== {12'h0, 1'b1, 32'h0}) badidle++;
            tick();
        end
        check("sat_strobe_low_count", lows, 0);
        check("sat_idle_port_errors", badidle, 0);
        check("sat_grant_held", {g0, g1}, 2'b01);
        req[0] = 1'b1; rw[0] = 1'b1;
        tick();
        check("sat_release_to_m0", {g0, g1}, 2'b10);

        // Reset landing on the edge after an accepted read suppresses its ready
        do_reset();
        req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 12'h010;
        tick();
        rst = 1'b1;
        tick();
        check("rst_after_accept", {rdy0, rdy1, g0, g1}, 4'b0000);
        check("rst_after_accept_data", rdata, 32'h0);
        rst = 1'b0;
        idle_inputs();

        // Randomized run against the reference model
        do_reset();
        for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
        owner = -1; run = 0; last = 1; erdy0 = 0; erdy1 = 0; erd = '0;
        pend[0] = 0; pend[1] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                if (pend[k]) begin
                    if (owner != k && $urandom_range(0, 19) == 0) begin
                        req[k] = 1'b0; pend[k] = 0;
                    end
                end else if ($urandom_range(0, 2) != 0) begin
                    req[k] = 1'b1; pend[k] = 1;
                    rw[k] = 1'($urandom_range(0, 1));
                    addr[k] = AW'($urandom_range(0, 4095));
                    wd[k] = $urandom;
                end else begin
                    req[k] = 1'b0;
                    addr[k] = AW'($urandom_range(0, 4095));
                end
                if ($urandom_range(0, 11) == 0) lock[k] = ~lock[k];
            end
            #4;
            acc = 0;
            if (owner >= 0) acc = req[owner];
            e_stb = 1'b1; e_addr = '0; e_rw = 1'b1; e_wd = '0;
            if (acc) begin
                e_stb = 1'b0; e_addr = addr[owner]; e_rw = rw[owner]; e_wd = wd[owner];
            end
            check("rand_port", {e_stb, e_addr, e_rw, e_wd} ^ {strobe_n, spm_addr, spm_rw, spm_wd} ^ {e_stb, e_addr, e_rw, e_wd},
                  {e_stb, e_addr, e_rw, e_wd});
            check("rand_grant_ready", {g0, g1, rdy0, rdy1}, {owner == 0, owner == 1, erdy0, erdy1});
            check("rand_read_data", rdata, erd);

            nr0 = acc && owner == 0;
            nr1 = acc && owner == 1;
            if (acc) begin
                if (rw[owner]) erd = ref_mem[addr[owner]];
                else ref_mem[addr[owner]] = wd[owner];
                pend[owner] = 0;
            end
            erdy0 = nr0; erdy1 = nr1;
            // run = cycles the current owner has held the port in this locked stretch
            if (owner < 0) begin
                o = pick(req[0], req[1], last); run = 1;
            end else if (lock[owner]) begin
                o = owner;
                if (run < LM) run++;
                else if (req[1 - owner]) begin o = 1 - owner; run = 1; end
            end else begin
                o = pick(req[0], req[1], last); run = 1;
            end
            owner = o;
            if (owner >= 0) last = owner;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
